// File: rtl/midi_pkg.sv
// Shared MIDI constants and types: status nibbles, controller numbers,
// running-status commands and parser FSM states.
package midi_pkg;

  localparam logic [3:0] ST_NOTEOFF = 4'h8;
  localparam logic [3:0] ST_NOTEON  = 4'h9;
  localparam logic [3:0] ST_CC      = 4'hB;
  localparam logic [3:0] ST_PROG    = 4'hC;
  localparam logic [3:0] ST_CHPRESS = 4'hD;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    RS_NONE,
    RS_NOTEOFF,
    RS_NOTEON,
    RS_CC,
    RS_IGNORE
  } rs_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_D1,
    S_D2
  } state_t;

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running status, channel filtering, real-time
// interleaving, and a last-note-priority monophonic note/gate register.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_note_on,
  output logic       o_note_off,
  output logic [6:0] o_ev_note,
  output logic [6:0] o_ev_vel,
  output logic [6:0] o_note,
  output logic       o_gate
);

  localparam logic [3:0] CH = 4'(CHANNEL);

  state_t     state_q, state_d;
  rs_t        rs_q, rs_d;
  logic       len2_q, len2_d;
  logic [6:0] d1_q, d1_d;
  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic [6:0] ev_note_q, ev_note_d;
  logic [6:0] ev_vel_q, ev_vel_d;
  logic [6:0] note_q, note_d;
  logic       gate_q, gate_d;

  logic       is_realtime, is_syscom, is_status;
  logic       ch_match;
  logic [3:0] status_nib;
  logic [6:0] data7;

  assign is_realtime = (i_rx_data[7:3] == 5'b11111);
  assign is_syscom   = (i_rx_data[7:3] == 5'b11110);
  assign is_status   = i_rx_data[7] && (i_rx_data[7:4] != 4'hF);
  assign status_nib  = i_rx_data[7:4];
  assign ch_match    = (OMNI != 0) || (i_rx_data[3:0] == CH);
  assign data7       = i_rx_data[6:0];

  // NOTE: every always_comb target gets a default first so no path can
  // leave it unassigned and infer a latch; pulses default low.
  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    len2_d     = len2_q;
    d1_d       = d1_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    ev_note_d  = ev_note_q;
    ev_vel_d   = ev_vel_q;
    note_d     = note_q;
    gate_d     = gate_q;

    if (i_rx_valid) begin
      if (is_realtime) begin
        // Real-time bytes may land mid-message and must leave it intact.
        state_d = state_q;
      end else if (is_syscom) begin
        rs_d    = RS_NONE;
        state_d = S_IDLE;
      end else if (is_status) begin
        state_d = S_D1;
        len2_d  = !((status_nib == ST_PROG) || (status_nib == ST_CHPRESS));
        if (!ch_match) begin
          rs_d = RS_IGNORE;
        end else begin
          case (status_nib)
            ST_NOTEOFF: rs_d = RS_NOTEOFF;
            ST_NOTEON:  rs_d = RS_NOTEON;
            ST_CC:      rs_d = RS_CC;
            default:    rs_d = RS_IGNORE;
          endcase
        end
      end else begin
        case (state_q)
          S_D1: begin
            if (len2_q) begin
              d1_d    = data7;
              state_d = S_D2;
            end
          end
          S_D2: begin
            state_d = S_D1;
            if ((rs_q == RS_NOTEON) && (data7 != 7'd0)) begin
              note_on_d = 1'b1;
              ev_note_d = d1_q;
              ev_vel_d  = data7;
              note_d    = d1_q;
              gate_d    = 1'b1;
            end else if ((rs_q == RS_NOTEOFF) || (rs_q == RS_NOTEON)) begin
              note_off_d = 1'b1;
              ev_note_d  = d1_q;
              ev_vel_d   = data7;
              // Releasing a note other than the sounding one keeps the gate.
              if (d1_q == note_q) gate_d = 1'b0;
            end else if ((rs_q == RS_CC) && (d1_q == CC_ALL_NOTES_OFF)) begin
              gate_d = 1'b0;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rs_q       <= RS_NONE;
      len2_q     <= 1'b0;
      d1_q       <= 7'd0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      ev_note_q  <= 7'd0;
      ev_vel_q   <= 7'd0;
      note_q     <= 7'd0;
      gate_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      len2_q     <= len2_d;
      d1_q       <= d1_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      ev_note_q  <= ev_note_d;
      ev_vel_q   <= ev_vel_d;
      note_q     <= note_d;
      gate_q     <= gate_d;
    end
  end

  assign o_note_on  = note_on_q;
  assign o_note_off = note_off_q;
  assign o_ev_note  = ev_note_q;
  assign o_ev_vel   = ev_vel_q;
  assign o_note     = note_q;
  assign o_gate     = gate_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: a channel-0 instance and an omni
// instance share one byte stream; expectations are hand-computed.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       on_a, off_a, gate_a;
  logic [6:0] ev_note_a, ev_vel_a, note_a;
  logic       on_b, off_b, gate_b;
  logic [6:0] ev_note_b, ev_vel_b, note_b;

  int checks = 0;
  int failures = 0;
  int on_cnt_a = 0, off_cnt_a = 0, on_cnt_b = 0, off_cnt_b = 0;
  int on_base, off_base, onb_base, offb_base;

  always #5 clk = ~clk;

  midi_msg_parser #(.CHANNEL(0), .OMNI(0)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_note_on(on_a), .o_note_off(off_a), .o_ev_note(ev_note_a),
    .o_ev_vel(ev_vel_a), .o_note(note_a), .o_gate(gate_a)
  );

  midi_msg_parser #(.CHANNEL(0), .OMNI(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_note_on(on_b), .o_note_off(off_b), .o_ev_note(ev_note_b),
    .o_ev_vel(ev_vel_b), .o_note(note_b), .o_gate(gate_b)
  );

  always @(negedge clk) begin
    if (on_a)  on_cnt_a++;
    if (off_a) off_cnt_a++;
    if (on_b)  on_cnt_b++;
    if (off_b) off_cnt_b++;
    if (on_a && off_a) begin
      failures++;
      $display("FAIL both_pulses_a got on=1 off=1 want not both");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the sampling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic snap();
    idle(2);
    on_base   = on_cnt_a;
    off_base  = off_cnt_a;
    onb_base  = on_cnt_b;
    offb_base = off_cnt_b;
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    check("rst_note_on",  32'(on_a),      32'd0);
    check("rst_note_off", 32'(off_a),     32'd0);
    check("rst_ev_note",  32'(ev_note_a), 32'd0);
    check("rst_ev_vel",   32'(ev_vel_a),  32'd0);
    check("rst_note",     32'(note_a),    32'd0);
    check("rst_gate",     32'(gate_a),    32'd0);
    rst = 1'b0;
    idle(1);

    // Basic note-on
    send(8'h90); send(8'h3C);
    check("pre_on_idle", 32'(on_a), 32'd0);
    send(8'h64);
    check("on1_pulse",   32'(on_a),      32'd1);
    check("on1_off",     32'(off_a),     32'd0);
    check("on1_ev_note", 32'(ev_note_a), 32'h3C);
    check("on1_ev_vel",  32'(ev_vel_a),  32'h64);
    check("on1_note",    32'(note_a),    32'h3C);
    check("on1_gate",    32'(gate_a),    32'd1);
    idle(1);
    check("on1_width", 32'(on_a), 32'd0);

    // Running status: new note retriggers, release of old note keeps gate
    send(8'h40); send(8'h50);
    check("rs_on_pulse", 32'(on_a),   32'd1);
    check("rs_on_note",  32'(note_a), 32'h40);
    send(8'h3C); send(8'h00);
    check("vel0_off_pulse", 32'(off_a),     32'd1);
    check("vel0_on_quiet",  32'(on_a),      32'd0);
    check("vel0_gate_held", 32'(gate_a),    32'd1);
    check("vel0_note",      32'(note_a),    32'h40);
    check("vel0_ev_note",   32'(ev_note_a), 32'h3C);
    check("vel0_ev_vel",    32'(ev_vel_a),  32'h00);

    send(8'h80); send(8'h40); send(8'h00);
    check("off_match_pulse", 32'(off_a),  32'd1);
    check("off_match_gate",  32'(gate_a), 32'd0);
    check("off_match_note",  32'(note_a), 32'h40);

    // Channel filter vs omni
    snap();
    send(8'h91); send(8'h3C); send(8'h64);
    snap();
    idle(0);
    check("ch1_a_gate",   32'(gate_a), 32'd0);
    check("omni_b_gate",  32'(gate_b), 32'd1);
    check("omni_b_note",  32'(note_b), 32'h3C);
    send(8'h91); send(8'h3C); send(8'h64);
    idle(2);
    check("ch1_a_no_on",  32'(on_cnt_a - on_base),  32'd0);
    check("omni_b_on",    32'(on_cnt_b - onb_base), 32'd1);
    send(8'hB0); send(8'h7B); send(8'h00);
    check("omni_b_anoff", 32'(gate_b), 32'd0);

    // Real-time byte mid-message
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    check("rt_on_pulse", 32'(on_a),     32'd1);
    check("rt_ev_vel",   32'(ev_vel_a), 32'h64);

    // SysEx aborts; program change re-targets length
    snap();
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    send(8'h90); send(8'h3C); send(8'hC0); send(8'h05); send(8'h64);
    idle(2);
    check("abort_no_on",  32'(on_cnt_a - on_base),   32'd0);
    check("abort_no_off", 32'(off_cnt_a - off_base), 32'd0);

    // All Notes Off
    send(8'h90); send(8'h45); send(8'h7F);
    check("ano_on_note", 32'(note_a), 32'h45);
    snap();
    send(8'hB0); send(8'h7B); send(8'h00);
    check("ano_gate", 32'(gate_a), 32'd0);
    idle(2);
    check("ano_no_on",  32'(on_cnt_a - on_base),   32'd0);
    check("ano_no_off", 32'(off_cnt_a - off_base), 32'd0);

    // Explicit note-off
    send(8'h90); send(8'h45); send(8'h7F);
    check("off2_gate_up", 32'(gate_a), 32'd1);
    send(8'h80); send(8'h45); send(8'h40);
    check("off2_pulse",  32'(off_a),    32'd1);
    check("off2_gate",   32'(gate_a),   32'd0);
    check("off2_ev_vel", 32'(ev_vel_a), 32'h40);

    // Reset mid-message
    send(8'h90); send(8'h45); send(8'h7F);
    send(8'h90); send(8'h3C);
    rst = 1'b1;
    #1;
    check("mid_rst_gate",    32'(gate_a),    32'd0);
    check("mid_rst_note",    32'(note_a),    32'd0);
    check("mid_rst_ev_note", 32'(ev_note_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    snap();
    send(8'h64);
    check("post_rst_no_pulse", 32'(on_a),   32'd0);
    check("post_rst_gate",     32'(gate_a), 32'd0);
    idle(2);
    check("post_rst_no_on", 32'(on_cnt_a - on_base), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Converts the raw MIDI byte stream from the UART receiver into note events plus a monophonic held-note register. Sits directly upstream of the note-number-to-DDS-increment table: `o_note` drives the table's 7-bit note input and `o_gate` enables the DDS output. The block handles running status, channel filtering, real-time byte interleaving and note-on-velocity-0-as-note-off.

## Interface
Parameters:
- `CHANNEL`, 0, MIDI channel to accept, 0–15.
- `OMNI`, 0, 1 = accept all channels and ignore `CHANNEL`.

Ports:
- `i_clk`, in, 1, system clock; the single clock domain.
- `i_rst`, in, 1, asynchronous, active-high reset.
- `i_rx_data`, in, 8, received byte; valid only while `i_rx_valid` = 1.
- `i_rx_valid`, in, 1, one-cycle strobe; at most one byte per cycle, no back-pressure.
- `o_note_on`, out, 1, one-cycle pulse: note-on accepted.
- `o_note_off`, out, 1, one-cycle pulse: note-off accepted, including note-on with velocity 0.
- `o_ev_note`, out, 7, note number of the last event; held between events.
- `o_ev_vel`, out, 7, velocity of the last event; held between events.
- `o_note`, out, 7, current mono note; feeds the DDS table.
- `o_gate`, out, 1, 1 while a note is held.

## Operation
Byte classes:
- `0xF8–0xFF` (real-time): ignored completely. No state change, even mid-message.
- `0xF0–0xF7` (system common / SysEx): clear running status (`rs = NONE`); go to `S_IDLE`.
- `0x80–0xEF` (channel status): abort any partial message.
  - Latch a running-status command: NOTEOFF (`0x8n`), NOTEON (`0x9n`) or CC (`0xBn`) if the channel matches; otherwise IGNORE.
  - Latch the data length: 1 for `0xCn` and `0xDn`, 2 for all others.
  - Go to `S_D1`.
- `0x00–0x7F` (data): handled by the FSM below.

FSM states `S_IDLE`, `S_D1`, `S_D2`:
- `S_IDLE`: data bytes are discarded.
- `S_D1`, data byte:
  - Length 1: message complete; stay in `S_D1`.
  - Length 2: store the byte as `d1`; go to `S_D2`.
- `S_D2`, data byte: this is `d2`. Message complete; return to `S_D1` (running status stays active).

Message completion:
- NOTEON with `d2` ≠ 0: pulse `o_note_on`. Set `o_ev_note = d1`, `o_ev_vel = d2`, `o_note = d1`, `o_gate = 1`. Last-note priority: a new note-on always retriggers.
- NOTEOFF, or NOTEON with `d2` = 0: pulse `o_note_off` and set `o_ev_note`/`o_ev_vel`. If `d1 == o_note`, clear `o_gate`; otherwise `o_gate` and `o_note` are unchanged.
- CC with `d1 = 123` (All Notes Off): clear `o_gate`, no pulse. Any other CC: no effect.
- IGNORE, or length-1 messages: no output change.

## Timing
- Reset values: all outputs 0, state `S_IDLE`, `rs = NONE`.
- Latency: pulses, `o_ev_*`, `o_note` and `o_gate` update on the clock edge that samples the completing byte. They are visible the following cycle, so latency is 1 cycle.
- Pulses are exactly one cycle wide. Back-to-back completions on consecutive cycles produce consecutive pulses.
- `o_note_on` and `o_note_off` are never asserted together.
- Reset asserted mid-message: the partial message and running status are lost immediately; outputs return to 0 asynchronously.
- Velocity 0 on NOTEON is handled exactly as NOTEOFF (same pulse, same gate rule).

## Structure
- Shared package `midi_pkg`:
  - Status nibble constants: `ST_NOTEOFF = 4'h8`, `ST_NOTEON = 4'h9`, `ST_CC = 4'hB`, `ST_PROG = 4'hC`, `ST_CHPRESS = 4'hD`.
  - `CC_ALL_NOTES_OFF = 7'd123`.
  - Running-status command typedef and FSM state typedef.
- Single flat module; no sub-module. Byte classification is combinational logic inside the module.

## Test plan
- Reset, then send `90 3C 64` → `o_note_on` pulse 1 cycle after the `64` strobe; `o_ev_note = 0x3C`, `o_ev_vel = 0x64`, `o_note = 0x3C`, `o_gate = 1`.
- Running status: `90 3C 64`, then `40 50`, then `3C 00` → note-on 0x3C, note-on 0x40 (`o_note = 0x40`), then `o_note_off` pulse with `o_gate` still 1 (0x3C ≠ `o_note`).
- `CHANNEL = 0`: send `91 3C 64` → no pulses, `o_gate` stays 0. Repeat with `OMNI = 1` → `o_note_on` pulses.
- Interleaved and aborted messages:
  - `90 3C F8 64` → note-on as normal; `F8` has no effect.
  - `90 3C F0 64` → nothing fires.
  - `90 3C C0 05 64` → nothing fires.
- Release paths: `90 45 7F` then `B0 7B 00` → `o_gate` falls 1 cycle after `00`, no pulse. `90 45 7F` then `80 45 40` → `o_note_off` pulse and `o_gate = 0`.
- Assert `i_rst` between `90 3C` and `64` → outputs 0; the following `64` is discarded and no pulse occurs.
